// File: rtl/melody_pkg.sv
// melody_pkg: shared FSM encoding, song-table entry layout and the
// pitch-to-key decode used by the melody sequencer and its song ROM.
package melody_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_NOTE = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // Song-table entry layout: {pitch[6:3], beats[2:0]}
   localparam int PITCH_W   = 4;
   localparam int BEATS_W   = 3;
   localparam int ENTRY_W   = PITCH_W + BEATS_W;
   localparam int PITCH_LSB = BEATS_W;
   localparam int BEATS_LSB = 0;
   localparam int KEYS_W    = 8;

   typedef logic [PITCH_W-1:0] pitch_t;
   typedef logic [BEATS_W-1:0] beats_t;
   typedef logic [ENTRY_W-1:0] entry_t;
   // Key vector is indexed the way the tone generator numbers its keys:
   // bit 0 = C1 (leftmost) ... bit 7 = C2.
   typedef logic [0:KEYS_W-1]  keys_t;

   localparam pitch_t PITCH_REST = 4'd0;
   localparam pitch_t PITCH_END  = 4'd15;

   // Pack a pitch and a beat count into one table entry.
   function automatic entry_t make_entry(input pitch_t pitch, input beats_t beats);
      return {pitch, beats};
   endfunction

   // Pitch 1..8 lights exactly one key; rests (0, 9..14) and END give silence.
   function automatic keys_t decode_pitch(input pitch_t pitch);
      keys_t onehot;
      case (pitch)
         4'd1:    onehot = 8'b1000_0000;
         4'd2:    onehot = 8'b0100_0000;
         4'd3:    onehot = 8'b0010_0000;
         4'd4:    onehot = 8'b0001_0000;
         4'd5:    onehot = 8'b0000_1000;
         4'd6:    onehot = 8'b0000_0100;
         4'd7:    onehot = 8'b0000_0010;
         4'd8:    onehot = 8'b0000_0001;
         default: onehot = '0;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: fixed song table, read combinationally at addr.
// Every index not listed below holds the END marker.
module melody_rom
   import melody_pkg::*;
#(
   parameter int IW = 5
) (
   input  logic [IW-1:0] addr,
   output entry_t        entry
);

   // Song contents: C1 x2, E1 x1, rest x1, C1 x1, END ...
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
      entry = make_entry(PITCH_END, 3'd0);
      case (addr)
         IW'(0):  entry = make_entry(4'd1, 3'd2);
         IW'(1):  entry = make_entry(4'd3, 3'd1);
         IW'(2):  entry = make_entry(PITCH_REST, 3'd1);
         IW'(3):  entry = make_entry(4'd1, 3'd1);
         default: ;
      endcase
   end

endmodule

// File: rtl/melody_seq.sv
// melody_seq: autoplay melody sequencer feeding the square-wave tone
// generator's one-hot key vector. Steps through melody_rom, holds each note
// for beats x BEAT_DIV cycles, then inserts GAP_CYC silent cycles.
// Optional build macro MELODY_TEMPO_EN adds a tempo[1:0] input that shortens
// the beat to BEAT_DIV >> tempo (BEAT_DIV must then be >= 16).
module melody_seq
   import melody_pkg::*;
#(
   parameter int BEAT_DIV = 1000,   // clk cycles per beat, >= 2
   parameter int GAP_CYC  = 50,     // silent cycles between notes, >= 1
   parameter int SONG_LEN = 32      // song-table depth
) (
   input  logic                        clk,
   input  logic                        reset,     // asynchronous, active low
   input  logic                        start,
   input  logic                        stop,
   input  logic                        loop_en,
`ifdef MELODY_TEMPO_EN
   input  logic [1:0]                  tempo,
`endif
   output logic [0:7]                  keys_out,
   output logic                        playing,
   output logic [$clog2(SONG_LEN)-1:0] note_idx,
   output logic                        done
);

   localparam int IW = $clog2(SONG_LEN);
   localparam int PW = $clog2(BEAT_DIV);
   // +1 keeps the gap counter at least one bit wide when GAP_CYC = 1.
   localparam int GW = $clog2(GAP_CYC + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(SONG_LEN - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   presc_q, presc_d;
   beats_t          beat_q, beat_d;
   logic [GW-1:0]   gap_q, gap_d;
   keys_t           keys_q, keys_d;
`ifdef MELODY_TEMPO_EN
   logic [1:0]      tempo_q, tempo_d;
`endif

   entry_t          entry;
   pitch_t          rom_pitch;
   beats_t          rom_beats;
   logic [PW-1:0]   beat_max;
   logic            is_end;
   logic            beat_wrap;
   logic            beat_last;
   logic            gap_last;
   logic            idx_last;
   logic            idx_zero;

   melody_rom #(.IW(IW)) u_rom (
      .addr  (idx_q),
      .entry (entry)
   );

   assign rom_pitch = entry[PITCH_LSB +: PITCH_W];
   assign rom_beats = entry[BEATS_LSB +: BEATS_W];
   assign is_end    = (rom_pitch == PITCH_END);

   // Last prescaler count of one beat; with tempo the beat is BEAT_DIV >> tempo.
`ifdef MELODY_TEMPO_EN
   assign beat_max  = PW'((BEAT_DIV >> tempo_q) - 1);
`else
   assign beat_max  = PW'(BEAT_DIV - 1);
`endif

   assign beat_wrap = (presc_q == beat_max);
   assign beat_last = (beat_q == 3'd1);
   assign gap_last  = (gap_q == GAP_MAX);
   assign idx_last  = (idx_q == IDX_LAST);
   assign idx_zero  = (idx_q == '0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stop overrides everything, including a simultaneous start.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
               if (is_end) begin
                  // END at index 0 means an empty song: never loop on it.
                  state_d = (loop_en && !idx_zero) ? S_LOAD : S_DONE;
               end else begin
                  state_d = S_NOTE;
               end
            end
            S_NOTE: begin
               if (beat_wrap && beat_last) state_d = S_GAP;
            end
            S_GAP: begin
               if (gap_last) state_d = (idx_last && !loop_en) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath next values: note index, beat timing, gap timing and registered keys.
   always_comb begin
      idx_d   = idx_q;
      presc_d = presc_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      keys_d  = '0;
`ifdef MELODY_TEMPO_EN
      tempo_d = tempo_q;
`endif
      if (!stop) begin
         case (state_q)
            S_IDLE: begin
               if (start) idx_d = '0;
            end
            S_LOAD: begin
               if (is_end) begin
                  if (loop_en && !idx_zero) idx_d = '0;
               end else begin
                  beat_d  = (rom_beats == 3'd0) ? 3'd1 : rom_beats;
                  presc_d = '0;
                  // Registered here so the key is valid on the very first NOTE cycle.
                  keys_d  = decode_pitch(rom_pitch);
`ifdef MELODY_TEMPO_EN
                  tempo_d = tempo;
`endif
               end
            end
            S_NOTE: begin
               keys_d = keys_q;
               if (beat_wrap) begin
                  presc_d = '0;
                  beat_d  = beat_q - 3'd1;
                  if (beat_last) begin
                     keys_d = '0;
                     gap_d  = '0;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            S_GAP: begin
               if (gap_last) begin
                  gap_d = '0;
                  if (idx_last) begin
                     if (loop_en) idx_d = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q   <= '0;
         presc_q <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         keys_q  <= '0;
`ifdef MELODY_TEMPO_EN
         tempo_q <= '0;
`endif
      end else begin
         idx_q   <= idx_d;
         presc_q <= presc_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         keys_q  <= keys_d;
`ifdef MELODY_TEMPO_EN
         tempo_q <= tempo_d;
`endif
      end
   end

   // Status outputs decoded from the current state
   always_comb begin
      playing = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_LOAD, S_NOTE, S_GAP: playing = 1'b1;
         S_DONE:                done    = 1'b1;
         default: ;
      endcase
   end

   assign keys_out = keys_q;
   assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: directed bench for melody_seq with BEAT_DIV=4 (or 16 with
// tempo=2 when MELODY_TEMPO_EN is defined), GAP_CYC=2. Cycle n is the
// n-th clock after the cycle in which start is presented.
module tb_melody_seq;

`ifdef MELODY_TEMPO_EN
   localparam int BD = 16;
`else
   localparam int BD = 4;
`endif
   localparam int GC = 2;
   localparam int SL = 32;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       loop_en;
`ifdef MELODY_TEMPO_EN
   logic [1:0] tempo;
`endif
   logic [0:7] keys_out;
   logic       playing;
   logic [4:0] note_idx;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   // Recorded traces: index 0 = loop_en low, 1 = loop_en high
   logic [0:7] tr_keys [0:1][0:63];
   logic       tr_play [0:1][0:63];
   logic       tr_done [0:1][0:63];
   logic [4:0] tr_idx  [0:1][0:63];

   typedef struct {
      int         lp;
      int         lo;
      int         hi;
      logic [0:7] keys;
      logic       play;
      logic       dn;
      int         idx;
   } vec_t;

   vec_t vecs [$];

   melody_seq #(
      .BEAT_DIV (BD),
      .GAP_CYC  (GC),
      .SONG_LEN (SL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
`ifdef MELODY_TEMPO_EN
      .tempo    (tempo),
`endif
      .keys_out (keys_out),
      .playing  (playing),
      .note_idx (note_idx),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [0:7] k, input logic p,
                             input logic d, input int i);
      check({tag, " keys"}, 32'(keys_out), 32'(k));
      check({tag, " playing"}, 32'(playing), 32'(p));
      check({tag, " done"}, 32'(done), 32'(d));
      check({tag, " idx"}, 32'(note_idx), i);
   endtask

   task automatic apply_reset();
      start = 1'b0;
      stop  = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Plays the song from a fresh reset and records ncyc cycles of outputs.
   task automatic run_trace(input int lp, input int ncyc);
      apply_reset();
      loop_en = (lp != 0);
      for (int c = 0; c < ncyc; c++) begin
         tr_keys[lp][c] = keys_out;
         tr_play[lp][c] = playing;
         tr_done[lp][c] = done;
         tr_idx[lp][c]  = note_idx;
         start = (c == 0);
         @(negedge clk);
      end
      start   = 1'b0;
      stop    = 1'b1;
      @(negedge clk);
      stop    = 1'b0;
      loop_en = 1'b0;
   endtask

   initial begin
      clk     = 1'b0;
      reset   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
`ifdef MELODY_TEMPO_EN
      tempo   = 2'd2;
`endif

      // Reset state while reset is held low
      @(negedge clk);
      check_outs("reset", 8'h00, 1'b0, 1'b0, 0);

      run_trace(0, 37);
      run_trace(1, 46);

      // Expected outputs per cycle range: {loop, first, last, keys, playing, done, idx}
      vecs.push_back('{0,  0,  0, 8'h00, 1'b0, 1'b0, 0});
      vecs.push_back('{0,  1,  1, 8'h00, 1'b1, 1'b0, 0});
      vecs.push_back('{0,  2,  9, 8'h80, 1'b1, 1'b0, 0});
      vecs.push_back('{0, 10, 11, 8'h00, 1'b1, 1'b0, 0});
      vecs.push_back('{0, 12, 12, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{0, 13, 16, 8'h20, 1'b1, 1'b0, 1});
      vecs.push_back('{0, 17, 18, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{0, 19, 19, 8'h00, 1'b1, 1'b0, 2});
      vecs.push_back('{0, 20, 25, 8'h00, 1'b1, 1'b0, 2});
      vecs.push_back('{0, 26, 26, 8'h00, 1'b1, 1'b0, 3});
      vecs.push_back('{0, 27, 30, 8'h80, 1'b1, 1'b0, 3});
      vecs.push_back('{0, 31, 32, 8'h00, 1'b1, 1'b0, 3});
      vecs.push_back('{0, 33, 33, 8'h00, 1'b1, 1'b0, 4});
      vecs.push_back('{0, 34, 34, 8'h00, 1'b0, 1'b1, 4});
      vecs.push_back('{0, 35, 36, 8'h00, 1'b0, 1'b0, 4});
      vecs.push_back('{1,  2,  9, 8'h80, 1'b1, 1'b0, 0});
      vecs.push_back('{1, 13, 16, 8'h20, 1'b1, 1'b0, 1});
      vecs.push_back('{1, 27, 30, 8'h80, 1'b1, 1'b0, 3});
      vecs.push_back('{1, 33, 33, 8'h00, 1'b1, 1'b0, 4});
      vecs.push_back('{1, 34, 34, 8'h00, 1'b1, 1'b0, 0});
      vecs.push_back('{1, 35, 42, 8'h80, 1'b1, 1'b0, 0});
      vecs.push_back('{1, 43, 44, 8'h00, 1'b1, 1'b0, 0});
      vecs.push_back('{1, 45, 45, 8'h00, 1'b1, 1'b0, 1});

      foreach (vecs[i]) begin
         for (int c = vecs[i].lo; c <= vecs[i].hi; c++) begin
            string tag;
            tag = $sformatf("L%0d c%0d", vecs[i].lp, c);
            check({tag, " keys"}, 32'(tr_keys[vecs[i].lp][c]), 32'(vecs[i].keys));
            check({tag, " playing"}, 32'(tr_play[vecs[i].lp][c]), 32'(vecs[i].play));
            check({tag, " done"}, 32'(tr_done[vecs[i].lp][c]), 32'(vecs[i].dn));
            check({tag, " idx"}, 32'(tr_idx[vecs[i].lp][c]), vecs[i].idx);
         end
      end

      // At most one key is ever lit
      for (int c = 0; c < 37; c++)
         check($sformatf("L0 c%0d onehot", c), 32'($countones(tr_keys[0][c]) <= 1), 32'd1);

      // Stop mid-note, start ignored while playing, stop beats start
      apply_reset();
      for (int c = 0; c < 23; c++) begin
         if (c == 7)  check_outs("ign c7", 8'h80, 1'b1, 1'b0, 0);
         if (c == 13) check_outs("stop c13", 8'h20, 1'b1, 1'b0, 1);
         if (c >= 15 && c <= 22)
            check_outs($sformatf("stop c%0d", c), 8'h00, 1'b0, 1'b0, 1);
         start = (c == 0) || (c == 6) || (c == 20);
         stop  = (c == 14) || (c == 20);
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;

      // Asynchronous reset mid-note, then replay from index 0
      apply_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_outs("ar c5", 8'h80, 1'b1, 1'b0, 0);
      #2 reset = 1'b0;
      #1 check_outs("ar async", 8'h00, 1'b0, 1'b0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check_outs("ar replay c1", 8'h00, 1'b1, 1'b0, 0);
      start = 1'b0;
      @(negedge clk);
      check_outs("ar replay c2", 8'h80, 1'b1, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
